// File: rtl/entrada_stdin.sv
// Memory-mapped stdin: a debounced button press pushes the synchronised switches into a FIFO; loads pop the oldest entry.
// Press is written DEBOUNCE+2 edges after btn rises; saida is combinational; presses arriving while full are dropped and flagged.
module entrada_stdin #(
   parameter int          DEPTH      = 8,
   parameter int          DEBOUNCE   = 16,
   parameter logic [31:0] STDIN_ADDR = 32'h000000F8,
   parameter logic [31:0] STAT_ADDR  = 32'h000000FC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  sw,
   input  logic        btn,
   input  logic [31:0] end_lei,
   input  logic        ler,
   output logic [31:0] saida,
   output logic        vazio,
   output logic        cheio,
   output logic        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH + 1);
   localparam int CW = $clog2(DEBOUNCE);

   logic          r_btn_m, r_btn_s;
   logic [7:0]    r_sw_m, r_sw_s;
   logic          r_deb;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_rp, r_wp;
   logic [NW-1:0] r_n;
   logic          r_ovf;
   logic [7:0]    r_mem [DEPTH];

   logic          w_accept, w_push, w_pop, w_wr, w_drop, w_stat_rd;
   logic [7:0]    w_head;
   logic [6:0]    w_n7;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_m <= 1'b0;
         r_btn_s <= 1'b0;
         r_sw_m  <= 8'h00;
         r_sw_s  <= 8'h00;
      end else begin
         r_btn_m <= btn;
         r_btn_s <= r_btn_m;
         r_sw_m  <= sw;
         r_sw_s  <= r_sw_m;
      end
   end

   // The level change is accepted on the same edge the counter would wrap.
   assign w_accept = (r_btn_s != r_deb) && (r_cnt == CW'(DEBOUNCE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb <= 1'b0;
         r_cnt <= '0;
      end else if (r_btn_s == r_deb) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_deb <= r_btn_s;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign vazio     = (r_n == '0);
   assign cheio     = (r_n == NW'(DEPTH));
   assign overflow  = r_ovf;
   assign w_push    = w_accept && r_btn_s;
   assign w_pop     = ler && (end_lei == STDIN_ADDR) && !vazio;
   assign w_wr      = w_push && (!cheio || w_pop);
   assign w_drop    = w_push && cheio && !w_pop;
   assign w_stat_rd = ler && (end_lei == STAT_ADDR);

   // Storage is deliberately left out of reset; emptiness is tracked by r_n alone.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= r_sw_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rp  <= '0;
         r_wp  <= '0;
         r_n   <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_wr)  r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_wr && !w_pop)      r_n <= r_n + 1'b1;
         else if (!w_wr && w_pop) r_n <= r_n - 1'b1;
         if (w_drop)         r_ovf <= 1'b1;
         else if (w_stat_rd) r_ovf <= 1'b0;
      end
   end

   assign w_head = vazio ? 8'h00 : r_mem[r_rp];
   assign w_n7   = 7'(r_n);

   // Status word: [15] overflow, [14] full, [13] data available, [7] empty, [6:0] count.
   always_comb begin
      saida = 32'd0;
      if (end_lei == STDIN_ADDR)
         saida = {23'd0, !vazio, w_head};
      else if (end_lei == STAT_ADDR)
         saida = {16'd0, r_ovf, cheio, !vazio, 5'd0, vazio, w_n7};
   end

endmodule

// File: tb/tb_entrada_stdin.sv
// Directed bench for entrada_stdin with DEPTH=4, DEBOUNCE=4.
module tb_entrada_stdin;
   localparam logic [31:0] A_DAT = 32'h000000F8;
   localparam logic [31:0] A_ST  = 32'h000000FC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  sw;
   logic        btn;
   logic [31:0] end_lei;
   logic        ler;
   logic [31:0] saida;
   logic        vazio, cheio, overflow;
   int          total = 0;
   int          bad   = 0;

   entrada_stdin #(.DEPTH(4), .DEBOUNCE(4)) dut (
      .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn), .end_lei(end_lei),
      .ler(ler), .saida(saida), .vazio(vazio), .cheio(cheio), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic l);
      end_lei = a;
      ler     = l;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [7:0] v);
      sw  = v;
      btn = 1'b1;
      repeat (8) tick();
      btn = 1'b0;
      repeat (8) tick();
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      rd(A_DAT, 1'b1);
      chk(tag, saida, exp);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; sw = 8'h00; btn = 1'b0; end_lei = 32'd0; ler = 1'b0;
      #12;
      chk("rst_vazio", {31'd0, vazio}, 32'd1);
      chk("rst_cheio", {31'd0, cheio}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;
      tick();
      rd(A_ST, 1'b0);       chk("idle_stat", saida, 32'h00000080);
      rd(32'h100, 1'b0);    chk("idle_other", saida, 32'h00000000);
      rd(A_DAT, 1'b1);      chk("idle_dat", saida, 32'h00000000);
      tick();
      rd(A_ST, 1'b0);       chk("idle_n0", saida, 32'h00000080);

      // single press: push lands on edge 6
      sw = 8'hA5; btn = 1'b1; ler = 1'b0;
      repeat (5) tick();
      chk("press_e5_vazio", {31'd0, vazio}, 32'd1);
      tick();
      chk("press_e6_vazio", {31'd0, vazio}, 32'd0);
      rd(A_DAT, 1'b1);      chk("press_read", saida, 32'h000001A5);
      tick();
      ler = 1'b0;
      chk("press_popped", {31'd0, vazio}, 32'd1);
      btn = 1'b0;
      repeat (8) tick();

      // bounce rejection
      for (int i = 0; i < 5; i++) begin
         btn = 1'b1; repeat (2) tick();
         btn = 1'b0; repeat (2) tick();
      end
      repeat (8) tick();
      rd(A_ST, 1'b0);       chk("bounce_none", saida, 32'h00000080);
      sw = 8'h3C; btn = 1'b1;
      repeat (8) tick();
      rd(A_ST, 1'b0);       chk("bounce_one", saida, 32'h00002001);
      btn = 1'b0;
      repeat (8) tick();
      rd(A_ST, 1'b0);       chk("release_nopush", saida, 32'h00002001);
      pop_chk("bounce_val", 32'h0000013C);
      ler = 1'b0;

      // order, overflow and wrap
      for (int v = 1; v <= 6; v++) press(8'(v));
      chk("full_cheio", {31'd0, cheio}, 32'd1);
      chk("full_ovf", {31'd0, overflow}, 32'd1);
      rd(A_ST, 1'b1);       chk("stat_ovf", saida, 32'h0000E004);
      tick();
      chk("stat_clr", saida, 32'h00006004);
      tick();
      pop_chk("pop1", 32'h00000101);
      pop_chk("pop2", 32'h00000102);
      pop_chk("pop3", 32'h00000103);
      pop_chk("pop4", 32'h00000104);
      pop_chk("pop_empty", 32'h00000000);
      ler = 1'b0;
      press(8'h07); press(8'h08); press(8'h09);
      pop_chk("wrap7", 32'h00000107);
      pop_chk("wrap8", 32'h00000108);
      pop_chk("wrap9", 32'h00000109);
      ler = 1'b0;

      // push and pop on the same edge while full
      for (int v = 1; v <= 4; v++) press(8'(v));
      sw = 8'h09; btn = 1'b1;
      repeat (5) tick();
      rd(A_DAT, 1'b1);      chk("simul_read", saida, 32'h00000101);
      tick();
      ler = 1'b0;
      rd(A_ST, 1'b0);       chk("simul_stat", saida, 32'h00006004);
      chk("simul_ovf", {31'd0, overflow}, 32'd0);
      btn = 1'b0;
      repeat (8) tick();
      pop_chk("simul_p2", 32'h00000102);
      pop_chk("simul_p3", 32'h00000103);
      pop_chk("simul_p4", 32'h00000104);
      pop_chk("simul_p9", 32'h00000109);
      pop_chk("simul_empty", 32'h00000000);
      ler = 1'b0;

      // asynchronous reset during a debounce count
      press(8'h55);
      rd(A_ST, 1'b0);       chk("pre_rst_stat", saida, 32'h00002001);
      btn = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_vazio", {31'd0, vazio}, 32'd1);
      rd(A_ST, 1'b0);       chk("arst_stat", saida, 32'h00000080);
      btn = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      rd(A_ST, 1'b0);       chk("post_rst_stat", saida, 32'h00000080);
      rd(A_DAT, 1'b0);      chk("post_rst_dat", saida, 32'h00000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
